cpu_run_ctrl: RTL

//  Parametrised run sequencer for the next-generation 9-bit CPU top level. Replaces the bare

---
 rtl/cpu_run_ctrl_if.sv | 29 ++
 rtl/cpu_run_ctrl.sv | 122 ++++++++++++
 2 files changed

// File: rtl/cpu_run_ctrl_if.sv
// Run-control bus between the top-level pins (master) and the run sequencer (slave).
interface cpu_run_ctrl_if #(
  parameter int PC_W  = 10,
  parameter int CYC_W = 16
);
  logic             start;
  logic [PC_W-1:0]  start_pc;
  logic             step_mode;
  logic             step;
  logic             halt_req;
  logic             mem_busy;
  logic             pc_load;
  logic [PC_W-1:0]  pc_load_val;
  logic             core_en;
  logic             done;
  logic             timeout_err;
  logic [CYC_W-1:0] cycle_cnt;
  logic [CYC_W-1:0] instr_cnt;

  modport master (
    output start, start_pc, step_mode, step, halt_req, mem_busy,
    input  pc_load, pc_load_val, core_en, done, timeout_err, cycle_cnt, instr_cnt
  );

  modport slave (
    input  start, start_pc, step_mode, step, halt_req, mem_busy,
    output pc_load, pc_load_val, core_en, done, timeout_err, cycle_cnt, instr_cnt
  );
endinterface

// File: rtl/cpu_run_ctrl.sv
// Launch/run/halt sequencer for the 9-bit CPU: entry-PC load, stall gating,
// single-step, watchdog and saturating cycle/instruction counters.
//
// state    | meaning
// S_IDLE   | out of reset, waiting for start
// S_LAUNCH | one cycle, PC loaded with the latched entry address
// S_RUN    | free running, core advances whenever memory is not busy
// S_PAUSE  | single-step, core advances once per step request
// S_DONE   | halted normally, done held
// S_FAULT  | watchdog expired, timeout_err held
module cpu_run_ctrl #(
  parameter int PC_W    = 10,
  parameter int CYC_W   = 16,
  parameter int TIMEOUT = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  cpu_run_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_LAUNCH, S_RUN, S_PAUSE, S_DONE, S_FAULT
  } state_t;

  localparam logic [CYC_W-1:0] CNT_MAX = '1;
  localparam logic [CYC_W-1:0] WD_LAST = CYC_W'(TIMEOUT - 1);

  state_t           state_q;
  logic [PC_W-1:0]  pc_q;
  logic [CYC_W-1:0] cycle_q, cycle_d;
  logic [CYC_W-1:0] instr_q, instr_d;
  logic             pc_load_q;
  logic             done_q;
  logic             tmo_q;
  logic             step_pend_q;

  logic active;
  logic core_en;
  logic halt_acc;
  logic wd_hit;

  always_comb begin
    active   = (state_q == S_RUN) || (state_q == S_PAUSE);
    core_en  = 1'b0;
    if (state_q == S_RUN)   core_en = ~bus.mem_busy;
    if (state_q == S_PAUSE) core_en = (step_pend_q | bus.step) & ~bus.mem_busy;
    halt_acc = bus.halt_req & core_en;
    wd_hit   = (TIMEOUT != 0) && (state_q == S_RUN) && (cycle_q == WD_LAST);

    // Counters only move while RUN/PAUSE and stick at all-ones.
    cycle_d = cycle_q;
    instr_d = instr_q;
    if (active) begin
      if (cycle_q != CNT_MAX)            cycle_d = cycle_q + 1'b1;
      if (core_en && instr_q != CNT_MAX) instr_d = instr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      pc_q        <= '0;
      cycle_q     <= '0;
      instr_q     <= '0;
      pc_load_q   <= 1'b0;
      done_q      <= 1'b0;
      tmo_q       <= 1'b0;
      step_pend_q <= 1'b0;
    end else begin
      pc_load_q   <= 1'b0;
      step_pend_q <= 1'b0;
      cycle_q     <= cycle_d;
      instr_q     <= instr_d;
      case (state_q)
        S_IDLE, S_DONE, S_FAULT: begin
          if (bus.start) begin
            state_q   <= S_LAUNCH;
            pc_q      <= bus.start_pc;
            cycle_q   <= '0;
            instr_q   <= '0;
            done_q    <= 1'b0;
            tmo_q     <= 1'b0;
            pc_load_q <= 1'b1;
          end
        end
        S_LAUNCH: state_q <= bus.step_mode ? S_PAUSE : S_RUN;
        S_RUN: begin
          // An accepted halt beats a watchdog expiry in the same cycle.
          if (halt_acc) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end else if (wd_hit) begin
            state_q <= S_FAULT;
            tmo_q   <= 1'b1;
          end else if (bus.step_mode) begin
            state_q <= S_PAUSE;
          end
        end
        S_PAUSE: begin
          if (halt_acc) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end else if (!bus.step_mode) begin
            state_q <= S_RUN;
          end else begin
            step_pend_q <= ~core_en & (step_pend_q | bus.step);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.pc_load     = pc_load_q;
  assign bus.pc_load_val = pc_q;
  assign bus.core_en     = core_en;
  assign bus.done        = done_q;
  assign bus.timeout_err = tmo_q;
  assign bus.cycle_cnt   = cycle_q;
  assign bus.instr_cnt   = instr_q;

endmodule
